// File: rtl/core_pkg.sv
// Core-wide widths and types shared by the writeback path.
package core_pkg;

  localparam int XLEN   = 64;
  localparam int ROB_W  = 6;
  localparam int PREG_W = 7;

  typedef logic [PREG_W-1:0] preg_tag_t;

  // One completed result as it travels from an execution unit to the PRF.
  typedef struct packed {
    preg_tag_t        tag;
    logic [XLEN-1:0]  data;
    logic [ROB_W-1:0] rob;
  } wb_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result buffer: small circular FIFO with flush, exposing its
// head entry and occupancy so the arbiter can pick without extra latency.
module wb_src_fifo
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush wins over everything; full/empty guards protect against misuse.
  assign do_push = push && !flush && (count_q != CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop  && !flush && (count_q != '0);

  // Next-state for pointers and occupancy (+1 / -1 / hold on enq+deq).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so no stale payload can ever be observed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NUM_SRC execution units and grants
// up to two per cycle round-robin onto the PRF write / wakeup ports.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_W      = core_pkg::ROB_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [NUM_SRC-1:0]  src_valid,
  output logic [NUM_SRC-1:0]  src_ready,
  input  preg_tag_t           src_tag  [NUM_SRC],
  input  logic [XLEN-1:0]     src_data [NUM_SRC],
  input  logic [ROB_W-1:0]    src_rob  [NUM_SRC],
  output logic                wen0,
  output logic                wen1,
  output preg_tag_t           wtag0,
  output preg_tag_t           wtag1,
  output logic [XLEN-1:0]     wdata0,
  output logic [XLEN-1:0]     wdata1,
  output logic [ROB_W-1:0]    wrob0,
  output logic [ROB_W-1:0]    wrob1
);

  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  wb_entry_t        head  [NUM_SRC];
  logic [CNT_W-1:0] count [NUM_SRC];
  logic [NUM_SRC-1:0] ne;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0] g0, g1;
  logic            found0, found1;

  function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] p);
    return (p == RR_W'(NUM_SRC - 1)) ? '0 : p + RR_W'(1);
  endfunction

  // One FIFO per source. Ready looks only at registered occupancy, so a full
  // FIFO stays not-ready even while its head is being granted.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    wb_entry_t push_entry;

    assign ne[gi]        = (count[gi] != '0);
    assign src_ready[gi] = (count[gi] < CNT_W'(FIFO_DEPTH)) && !flush;
    assign push[gi]      = src_valid[gi] && src_ready[gi];
    assign pop[gi]       = (wen0 && (g0 == RR_W'(gi))) ||
                           (wen1 && (g1 == RR_W'(gi)));
    assign push_entry    = '{tag: src_tag[gi], data: src_data[gi], rob: src_rob[gi]};

    wb_src_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push[gi]),
      .push_entry (push_entry),
      .pop        (pop[gi]),
      .head       (head[gi]),
      .count      (count[gi])
    );
  end

  // Two-grant round-robin pick from registered FIFO state: g0 scans from the
  // pointer, g1 scans from just past g0 and can never land on g0 again.
  always_comb begin : pick
    logic [RR_W-1:0] cand;
    cand   = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    g0     = '0;
    g1     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = RR_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found0 && ne[cand]) begin
        found0 = 1'b1;
        g0     = cand;
      end
    end
    for (int k = 1; k < NUM_SRC; k++) begin
      cand = RR_W'((int'(g0) + k) % NUM_SRC);
      if (found0 && !found1 && ne[cand]) begin
        found1 = 1'b1;
        g1     = cand;
      end
    end
  end

  // Flush suppresses both ports for the cycle it is asserted.
  assign wen0 = found0 && !flush;
  assign wen1 = found1 && !flush;

  // Port payloads are held at zero whenever the port is idle.
  always_comb begin
    wtag0  = '0;
    wdata0 = '0;
    wrob0  = '0;
    wtag1  = '0;
    wdata1 = '0;
    wrob1  = '0;
    if (wen0) begin
      wtag0  = head[g0].tag;
      wdata0 = head[g0].data;
      wrob0  = head[g0].rob;
    end
    if (wen1) begin
      wtag1  = head[g1].tag;
      wdata1 = head[g1].data;
      wrob1  = head[g1].rob;
    end
  end

  // Pointer moves past the last source granted this cycle; holds when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (wen1)      rr_ptr_d = rr_inc(g1);
    else if (wen0) rr_ptr_d = rr_inc(g0);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, stream phases
// and a per-source scoreboard watching every write-port beat.
module tb_wb_arbiter;
  import core_pkg::*;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [NS-1:0] src_valid = '0;
  logic [NS-1:0] src_ready;
  preg_tag_t        src_tag  [NS];
  logic [XLEN-1:0]  src_data [NS];
  logic [ROB_W-1:0] src_rob  [NS];
  logic wen0, wen1;
  preg_tag_t wtag0, wtag1;
  logic [XLEN-1:0] wdata0, wdata1;
  logic [ROB_W-1:0] wrob0, wrob1;

  wb_arbiter #(.XLEN(XLEN), .NUM_SRC(NS), .FIFO_DEPTH(2), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data), .src_rob(src_rob),
    .wen0(wen0), .wen1(wen1), .wtag0(wtag0), .wtag1(wtag1),
    .wdata0(wdata0), .wdata1(wdata1), .wrob0(wrob0), .wrob1(wrob1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Data carries the source id in bits [42:40] so the scoreboard can route it.
  function automatic logic [XLEN-1:0] mk_data(input int src, input int val);
    return (XLEN'(src) << 40) | XLEN'(val);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { int src; wb_entry_t e; } sb_t;
  sb_t sb_q[$];

  logic bp_phase = 1'b0;
  int   cyc = 0;
  int   last_g [NS];
  int   grants [NS];
  int   max_gap = 0;
  int   ready0_low = 0;

  task automatic sb_check(input string port, input preg_tag_t t,
                          input logic [XLEN-1:0] d, input logic [ROB_W-1:0] r);
    int s;
    int hit;
    s = int'(d[42:40]);
    hit = -1;
    for (int k = 0; k < sb_q.size(); k++) begin
      if (hit < 0 && sb_q[k].src == s) hit = k;
    end
    n_cmp++;
    if (hit < 0) begin
      n_err++;
      $display("FAIL sb_%s_unexpected: got tag %0d data 0x%0h, want no beat from src %0d", port, t, d, s);
    end else begin
      if (sb_q[hit].e.tag !== t || sb_q[hit].e.data !== d || sb_q[hit].e.rob !== r) begin
        n_err++;
        $display("FAIL sb_%s_payload: got tag %0d data 0x%0h rob %0d, want tag %0d data 0x%0h rob %0d",
                 port, t, d, r, sb_q[hit].e.tag, sb_q[hit].e.data, sb_q[hit].e.rob);
      end
      sb_q.delete(hit);
    end
    if (bp_phase && s < NS) begin
      if (last_g[s] >= 0 && (cyc - last_g[s]) > max_gap) max_gap = cyc - last_g[s];
      last_g[s] = cyc;
      grants[s]++;
    end
  endtask

  // Monitor: sample on the falling edge, compare grants, then record accepts.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        sb_q.delete();
      end else begin
        if (wen1) check("wen1_implies_wen0", 64'(wen0), 64'(1));
        if (wen0) sb_check("p0", wtag0, wdata0, wrob0);
        if (wen1) sb_check("p1", wtag1, wdata1, wrob1);
        if (flush) begin
          sb_q.delete();
        end else begin
          for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_ready[i])
              sb_q.push_back('{src: i, e: '{tag: src_tag[i], data: src_data[i], rob: src_rob[i]}});
          end
        end
        if (bp_phase && !src_ready[0]) ready0_low++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [NS-1:0]       valid;
    logic [NS-1:0][6:0]  tag;
    bit                  drv_sp;
    bit                  exp_sp;
    logic                w0, w1;
    logic [6:0]          t0, t1;
    int                  s0;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] v, input int a, input int b, input int c,
                               input int d, input int mode, input logic w0, input logic w1,
                               input int t0, input int t1, input int s0);
    vec_t r;
    r.valid  = v;
    r.tag[0] = 7'(a);
    r.tag[1] = 7'(b);
    r.tag[2] = 7'(c);
    r.tag[3] = 7'(d);
    r.drv_sp = mode[0];
    r.exp_sp = mode[1];
    r.w0 = w0;
    r.w1 = w1;
    r.t0 = 7'(t0);
    r.t1 = 7'(t1);
    r.s0 = s0;
    return r;
  endfunction

  task automatic drive(input logic [NS-1:0] v, input int t0, input int t1, input int t2, input int t3);
    int tg [NS];
    tg[0] = t0; tg[1] = t1; tg[2] = t2; tg[3] = t3;
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = v[i];
      src_tag[i]   = 7'(tg[i]);
      src_data[i]  = mk_data(i, tg[i]);
      src_rob[i]   = ROB_W'(tg[i]);
    end
  endtask

  // Continuous streaming on all sources, holding payload until accepted.
  logic [NS-1:0] acc = '0;
  int seq [NS];
  task automatic stream_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) seq[i]++;
        src_valid[i] = 1'b1;
        src_tag[i]   = 7'(64 + i * 16 + seq[i] % 16);
        src_data[i]  = mk_data(i, 1000 + seq[i]);
        src_rob[i]   = ROB_W'(seq[i]);
      end
      @(negedge clk);
      acc = src_valid & src_ready;
    end
  endtask

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < NS; i++) begin
      src_tag[i] = '0; src_data[i] = '0; src_rob[i] = '0;
      seq[i] = 0; last_g[i] = -1; grants[i] = 0;
    end
    vecs[0]  = mkv(4'b1111, 10, 11, 12, 13, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(4'b0000, 0, 0, 0, 0, 0, 1, 1, 10, 11, 0);
    vecs[2]  = mkv(4'b0000, 0, 0, 0, 0, 0, 1, 1, 12, 13, 2);
    vecs[3]  = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkv(4'b0001, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[5]  = mkv(4'b0000, 0, 0, 0, 0, 2, 1, 0, 5, 0, 0);
    vecs[6]  = mkv(4'b0011, 20, 21, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(4'b0000, 0, 0, 0, 0, 0, 1, 1, 21, 20, 1);
    vecs[8]  = mkv(4'b0100, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(4'b0100, 0, 0, 31, 0, 0, 1, 0, 30, 0, 2);
    vecs[10] = mkv(4'b0100, 0, 0, 32, 0, 0, 1, 0, 31, 0, 2);
    vecs[11] = mkv(4'b0000, 0, 0, 0, 0, 0, 1, 0, 32, 0, 2);
    vecs[12] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wen0", 64'(wen0), 64'(0));
    check("rst_wen1", 64'(wen1), 64'(0));
    check("rst_wtag0", 64'(wtag0), 64'(0));
    check("rst_wdata0", 64'(wdata0), 64'(0));
    check("rst_wrob1", 64'(wrob1), 64'(0));
    check("rst_ready", 64'(src_ready), 64'(4'b1111));
    #2 reset = 1'b1;

    // Table-driven directed vectors
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      drive(vecs[k].valid, int'(vecs[k].tag[0]), int'(vecs[k].tag[1]),
            int'(vecs[k].tag[2]), int'(vecs[k].tag[3]));
      if (vecs[k].drv_sp) begin
        src_data[0] = 64'hDEAD_BEEF;
        src_rob[0]  = ROB_W'(3);
      end
      @(negedge clk);
      check($sformatf("v%0d_wen0", k), 64'(wen0), 64'(vecs[k].w0));
      check($sformatf("v%0d_wen1", k), 64'(wen1), 64'(vecs[k].w1));
      check($sformatf("v%0d_ready", k), 64'(src_ready), 64'(4'b1111));
      if (vecs[k].w0) begin
        check($sformatf("v%0d_wtag0", k), 64'(wtag0), 64'(vecs[k].t0));
        check($sformatf("v%0d_wdata0", k), 64'(wdata0),
              vecs[k].exp_sp ? 64'hDEAD_BEEF : 64'(mk_data(vecs[k].s0, int'(vecs[k].t0))));
        check($sformatf("v%0d_wrob0", k), 64'(wrob0),
              vecs[k].exp_sp ? 64'(3) : 64'(ROB_W'(vecs[k].t0)));
      end
      if (vecs[k].w1) check($sformatf("v%0d_wtag1", k), 64'(wtag1), 64'(vecs[k].t1));
    end

    // Backpressure: all sources stream continuously
    bp_phase = 1'b1;
    acc = '0;
    stream_cycles(40);
    @(posedge clk); #1;
    src_valid = '0;
    repeat (4) @(negedge clk);
    bp_phase = 1'b0;
    check("bp_ready0_dropped", 64'(ready0_low > 0), 64'(1));
    check("bp_max_gap_le2", 64'(max_gap), 64'(max_gap <= 2 ? max_gap : 2));
    for (int i = 0; i < NS; i++)
      check($sformatf("bp_grants_src%0d", i), 64'(grants[i] >= 15), 64'(1));
    check("bp_sb_drained", 64'(sb_q.size()), 64'(0));

    // Asynchronous reset between edges while streaming
    acc = '0;
    stream_cycles(4);
    @(posedge clk); #2;
    check("arst_pre_wen0", 64'(wen0), 64'(1));
    #1;
    reset = 1'b0;
    src_valid = '0;
    #1;
    check("arst_wen0_drop", 64'(wen0), 64'(0));
    check("arst_wen1_drop", 64'(wen1), 64'(0));
    check("arst_wtag0_zero", 64'(wtag0), 64'(0));
    check("arst_wdata1_zero", 64'(wdata1), 64'(0));
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("arst_no_stale_wen0", 64'(wen0), 64'(0));
    end
    @(posedge clk); #1;
    drive(4'b1010, 0, 70, 0, 71);
    @(negedge clk);
    check("arst_new_wen0_early", 64'(wen0), 64'(0));
    @(posedge clk); #1;
    src_valid = '0;
    @(negedge clk);
    check("arst_new_wen0", 64'(wen0), 64'(1));
    check("arst_new_wtag0", 64'(wtag0), 64'(70));
    check("arst_new_wen1", 64'(wen1), 64'(1));
    check("arst_new_wtag1", 64'(wtag1), 64'(71));

    // Flush with src0 holding 2 entries and src1 holding 1
    @(posedge clk); #1;
    drive(4'b0011, 50, 51, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(4'b1101, 52, 0, 53, 54);
    @(negedge clk);
    check("fl_c2_wtag0", 64'(wtag0), 64'(50));
    check("fl_c2_wtag1", 64'(wtag1), 64'(51));
    @(posedge clk); #1;
    drive(4'b0011, 55, 56, 0, 0);
    @(negedge clk);
    check("fl_c3_wtag0", 64'(wtag0), 64'(53));
    check("fl_c3_wtag1", 64'(wtag1), 64'(54));
    @(posedge clk); #1;
    drive(4'b0011, 57, 58, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_wen0", 64'(wen0), 64'(0));
    check("fl_wen1", 64'(wen1), 64'(0));
    check("fl_ready", 64'(src_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    src_valid = '0;
    @(negedge clk);
    check("fl_after_wen0", 64'(wen0), 64'(0));
    check("fl_after_ready", 64'(src_ready), 64'(4'b1111));
    @(posedge clk); #1;
    drive(4'b0010, 0, 60, 0, 0);
    @(negedge clk);
    check("fl_push_wen0_early", 64'(wen0), 64'(0));
    @(posedge clk); #1;
    src_valid = '0;
    @(negedge clk);
    check("fl_push_wen0", 64'(wen0), 64'(1));
    check("fl_push_wtag0", 64'(wtag0), 64'(60));
    check("fl_push_wen1", 64'(wen1), 64'(0));

    repeat (3) @(negedge clk);
    check("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the physical register file's two write ports. It collects results from NUM_SRC execution units, buffers each unit's results in a small per-source FIFO, and grants up to two results per cycle round-robin. Granted results drive PRF write port 0/1, and the same outputs serve as the wakeup/completion broadcast to the issue queue and ROB.

## Interface
- XLEN, core_pkg::XLEN, data width
- NUM_SRC, 4, number of execution-unit result sources (ALU0, ALU1, MUL, LSU); legal range 2..8
- FIFO_DEPTH, 2, entries per source FIFO; legal values 2 or 4
- ROB_W, core_pkg::ROB_W, ROB index width
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low; state cleared while 0
- flush  in  1  synchronous pipeline flush, e.g. mispredict
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source accept; src_ready[i] = (count[i] < FIFO_DEPTH) && !flush
- src_tag  in  NUM_SRC x preg_tag_t  destination physical register
- src_data  in  NUM_SRC x XLEN  result value
- src_rob  in  NUM_SRC x ROB_W  ROB index of producing instruction
- wen0, wen1  out  1 each  write/broadcast valid, port 0 and port 1
- wtag0, wtag1  out  preg_tag_t each  destination tag
- wdata0, wdata1  out  XLEN each  result data
- wrob0, wrob1  out  ROB_W each  ROB index for completion marking

## Operation
- Handshake: a transfer on source i occurs in a cycle when src_valid[i] && src_ready[i]. On that edge, {tag, data, rob} is written at the tail of FIFO i. A source holds its payload stable while valid and not ready.
- src_ready depends only on the registered count, with no same-cycle dequeue pass-through. A full FIFO therefore drops ready even in a cycle where its head is being granted.
- Head select is combinational from registered FIFO state. ne[i] = (count[i] != 0).
- Round-robin pointer rr_ptr is clog2(NUM_SRC) bits wide:
  - g0 is the first i with ne[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - g1 is the first i with ne[i] and i != g0, scanning from g0+1 modulo NUM_SRC.
- Port outputs:
  - wen0 = any ne.
  - wen1 = at least two sources non-empty.
  - wen1 is never 1 while wen0 is 0.
  - w*0 carries the head of g0; w*1 carries the head of g1.
- Granted FIFOs pop their head on the edge.
- rr_ptr update: if wen1, rr_ptr <= g1+1; else if wen0, rr_ptr <= g0+1; else it holds. All increments are modulo NUM_SRC.
- A source is never granted twice in one cycle, even with 2 entries queued.
- FIFO per source: circular rd/wr pointers with wrap modulo FIFO_DEPTH. count is updated +1 / −1 / 0 for simultaneous enq and deq. Enqueue into a FIFO holding 1 entry while popping leaves count at 1.
- flush, in the asserting cycle:
  - wen0 = wen1 = 0.
  - No pop, no enqueue; src_ready = 0.
  - On the edge, all counts and pointers go to 0. rr_ptr is unchanged.
- Tags are passed through unmodified; x0 handling stays in rename.
- Two sources with the same tag in one cycle is illegal upstream. If it occurs, both are granted and the PRF resolves it with port 0 priority.

## Timing
- Latency: a result accepted at edge N appears on wen0/wen1 in the cycle after edge N, at the earliest. Accept-to-PRF-write is 1 cycle, and the PRF bypass makes the value readable in that same cycle.
- Throughput: 2 results/cycle aggregate, 1 result/cycle per source.
- Reset (reset = 0), asynchronously:
  - counts, pointers and rr_ptr go to 0.
  - wen0 = wen1 = 0.
  - w-tag/data/rob outputs = 0; the FIFO storage is cleared.
  - src_ready = 1 once flush = 0.
- Reset asserted mid-transfer discards all buffered results. No output pulse appears on deassertion.
- All outputs are functions of registered state plus flush. There is no combinational path from src_valid to wen*.

## Structure
- core_pkg holds preg_tag_t, XLEN and ROB_W.
- Add wb_entry_t to core_pkg: packed struct {preg_tag_t tag; logic [XLEN-1:0] data; logic [ROB_W-1:0] rob;}.
- One sub-module, wb_src_fifo: parameterised FIFO_DEPTH, a wb_entry_t payload, with push/pop/count/head/flush ports. It is instantiated NUM_SRC times.
- The round-robin two-grant picker stays inline in wb_arbiter.

## Test plan
- Reset, then a single result: src0 sends tag 5, data 0xDEAD_BEEF, rob 3. Required: wen0 = 1 next cycle with those values, wen1 = 0, and rr_ptr then becomes 1.
- Four sources valid in the same cycle (tags 10–13), rr_ptr = 0:
  - cycle+1: ports carry tag 10 and 11.
  - cycle+2: ports carry tag 12 and 13.
  - cycle+3: wen0 = wen1 = 0.
- src2 alone streams 3 back-to-back results:
  - src2 is granted on port 0 only, one result per cycle, in order.
  - src_ready[2] stays 1.
- Backpressure: src0 pushes continuously while src1–src3 also push continuously.
  - src_ready[0] drops while its FIFO is full.
  - No result is lost or duplicated; scoreboard every tag/data pair.
  - Each source is granted at least once per 2 cycles.
- Flush with src0 holding 2 entries and src1 holding 1: in the flush cycle wen0 = wen1 = 0 and src_ready = 0. On the following cycles the FIFOs are empty, and a new push on src1 is written back 1 cycle after acceptance.
- Asynchronous reset asserted mid-stream, between clock edges:
  - wen0/wen1 drop immediately.
  - After release, no stale tag appears.
  - The first new result has latency 1 and is granted starting from rr_ptr = 0.
